parking_exit_controller: RTL and testbench

Exit-side companion to the parking-lot allocator: records the entry hour of every vehicle the allocator places, and services exit requests. For each exit it computes the stay duration (current hour minus entry hour, 4-bit wrap-around), multiplies it by the hourly rate to produce a fee, holds the fee for the toll display/payment logic, and frees the slot on acknowledgement. It owns the authoritative slot-occupancy vector that the allocator consumes as its availability input.

---
 rtl/parking_exit_controller.sv | 119 +++++++++++
 tb/tb_parking_exit_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_exit_controller.sv
// rtl/parking_exit_controller.sv - slot occupancy, entry-time store and exit fee FSM
module parking_exit_controller #(
    parameter logic [3:0] RATE = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       park_valid,
    input  logic [3:0] park_slot,
    input  logic       exit_valid,
    input  logic [1:0] exit_slot,
    output logic       exit_ready,
    input  logic       fee_ack,
    output logic       fee_valid,
    output logic [7:0] fee,
    output logic [3:0] duration,
    output logic [3:0] slot_busy,
    output logic [3:0] cur_time,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_SUB, S_MUL, S_DONE} state_t;

    state_t     r_state;
    logic [3:0] r_cur_time;
    logic [3:0] r_slot_busy;
    logic [3:0] r_entry_time [4];
    logic [1:0] r_slot;
    logic [3:0] r_lat_time;
    logic [3:0] r_duration;
    logic [7:0] r_fee;
    logic       r_fee_valid;
    logic       r_exit_ready;
    logic       r_err;

    logic       w_park_onehot;
    logic       w_park_hit_busy;
    logic       w_park_ok;
    logic       w_park_err;
    logic [1:0] w_park_idx;
    logic       w_exit_go;
    logic       w_exit_err;
    logic [3:0] w_clr_mask;
    logic [3:0] w_set_mask;
    logic [3:0] w_charge;

    assign w_park_onehot   = (park_slot != 4'd0) && ((park_slot & (park_slot - 4'd1)) == 4'd0);
    assign w_park_hit_busy = |(park_slot & r_slot_busy);
    assign w_park_ok       = park_valid && w_park_onehot && !w_park_hit_busy;
    // An all-zero park_slot means the lot is full: silently ignored.
    assign w_park_err      = park_valid && (park_slot != 4'd0) && (!w_park_onehot || w_park_hit_busy);
    assign w_park_idx      = {park_slot[3] | park_slot[2], park_slot[3] | park_slot[1]};

    assign w_exit_go  = (r_state == S_IDLE) && exit_valid && r_slot_busy[exit_slot];
    assign w_exit_err = (r_state == S_IDLE) && exit_valid && !r_slot_busy[exit_slot];

    assign w_clr_mask = (r_state == S_DONE && fee_ack) ? (4'b0001 << r_slot) : 4'b0000;
    assign w_set_mask = w_park_ok ? park_slot : 4'b0000;
    assign w_charge   = (r_duration == 4'd0) ? 4'd1 : r_duration;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_time   <= 4'd0;
            r_slot_busy  <= 4'd0;
            for (int i = 0; i < 4; i++) r_entry_time[i] <= 4'd0;
            r_slot       <= 2'd0;
            r_lat_time   <= 4'd0;
            r_duration   <= 4'd0;
            r_fee        <= 8'd0;
            r_fee_valid  <= 1'b0;
            r_exit_ready <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            if (tick) r_cur_time <= r_cur_time + 4'd1;
            r_slot_busy <= (r_slot_busy & ~w_clr_mask) | w_set_mask;
            if (w_park_ok) r_entry_time[w_park_idx] <= r_cur_time;
            r_err <= w_park_err || w_exit_err;

            case (r_state)
                S_IDLE: begin
                    if (w_exit_go) begin
                        r_slot       <= exit_slot;
                        r_lat_time   <= r_cur_time;
                        r_exit_ready <= 1'b0;
                        r_state      <= S_SUB;
                    end
                end
                S_SUB: begin
                    r_duration <= r_lat_time - r_entry_time[r_slot];
                    r_state    <= S_MUL;
                end
                S_MUL: begin
                    // Minimum one-hour charge; 15*15 fits in 8 bits.
                    r_fee       <= {4'd0, w_charge} * {4'd0, RATE};
                    r_fee_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (fee_ack) begin
                        r_fee_valid  <= 1'b0;
                        r_exit_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign exit_ready = r_exit_ready;
    assign fee_valid  = r_fee_valid;
    assign fee        = r_fee;
    assign duration   = r_duration;
    assign slot_busy  = r_slot_busy;
    assign cur_time   = r_cur_time;
    assign err        = r_err;

endmodule

// File: tb/tb_parking_exit_controller.sv
// tb/tb_parking_exit_controller.sv - directed and random bench for parking_exit_controller
module tb_parking_exit_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, park_valid, exit_valid, fee_ack;
    logic [3:0] park_slot;
    logic [1:0] exit_slot;

    logic       a_ready, a_fv, a_err, b_ready, b_fv, b_err;
    logic [7:0] a_fee, b_fee;
    logic [3:0] a_dur, a_busy, a_time, b_dur, b_busy, b_time;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: occupancy, entry hours, and an exit record aged in edges.
    int m_time;
    bit m_busy [4];
    int m_entry [4];
    bit m_in_exit;
    int m_age, m_slot, m_t0, m_dur, m_fee2, m_fee15;
    bit m_err;

    parking_exit_controller #(.RATE(4'd2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .park_valid(park_valid), .park_slot(park_slot),
        .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(a_ready), .fee_ack(fee_ack),
        .fee_valid(a_fv), .fee(a_fee), .duration(a_dur), .slot_busy(a_busy), .cur_time(a_time),
        .err(a_err));

    parking_exit_controller #(.RATE(4'd15)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .park_valid(park_valid), .park_slot(park_slot),
        .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(b_ready), .fee_ack(fee_ack),
        .fee_valid(b_fv), .fee(b_fee), .duration(b_dur), .slot_busy(b_busy), .cur_time(b_time),
        .err(b_err));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] busy_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_time = 0; m_in_exit = 0; m_age = 0; m_slot = 0; m_t0 = 0;
        m_dur = 0; m_fee2 = 0; m_fee15 = 0; m_err = 0;
        for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_entry[i] = 0; end
    endtask

    task automatic check_all();
        bit fv;
        fv = m_in_exit && (m_age >= 2);
        chk("a_ready", 8'(a_ready), 8'(!m_in_exit));
        chk("b_ready", 8'(b_ready), 8'(!m_in_exit));
        chk("a_fee_valid", 8'(a_fv), 8'(fv));
        chk("b_fee_valid", 8'(b_fv), 8'(fv));
        chk("a_duration", 8'(a_dur), 8'(m_dur));
        chk("b_duration", 8'(b_dur), 8'(m_dur));
        chk("a_fee", a_fee, 8'(m_fee2));
        chk("b_fee", b_fee, 8'(m_fee15));
        chk("a_slot_busy", 8'(a_busy), 8'(busy_vec()));
        chk("b_slot_busy", 8'(b_busy), 8'(busy_vec()));
        chk("a_cur_time", 8'(a_time), 8'(m_time));
        chk("b_cur_time", 8'(b_time), 8'(m_time));
        chk("a_err", 8'(a_err), 8'(m_err));
        chk("b_err", 8'(b_err), 8'(m_err));
    endtask

    task automatic step(input bit t, input bit pv, input logic [3:0] ps,
                        input bit ev, input logic [1:0] es, input bit ack);
        bit nb [4];
        bit nerr;
        int idx, ones, charge;
        tick = t; park_valid = pv; park_slot = ps;
        exit_valid = ev; exit_slot = es; fee_ack = ack;
        nerr = 0;
        for (int i = 0; i < 4; i++) nb[i] = m_busy[i];
        ones = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (ps[i]) begin ones++; idx = i; end
        if (pv && ones != 0) begin
            if (ones != 1 || m_busy[idx]) nerr = 1;
            else begin nb[idx] = 1; m_entry[idx] = m_time; end
        end
        if (!m_in_exit) begin
            if (ev) begin
                if (m_busy[es]) begin m_in_exit = 1; m_age = 0; m_slot = es; m_t0 = m_time; end
                else nerr = 1;
            end
        end else if (m_age >= 2 && ack) begin
            m_in_exit = 0; nb[m_slot] = 0;
        end else begin
            m_age++;
            if (m_age == 1) m_dur = (m_t0 - m_entry[m_slot] + 16) % 16;
            if (m_age == 2) begin
                charge = (m_dur == 0) ? 1 : m_dur;
                m_fee2 = charge * 2; m_fee15 = charge * 15;
            end
        end
        for (int i = 0; i < 4; i++) m_busy[i] = nb[i];
        m_time = (m_time + (t ? 1 : 0)) % 16;
        m_err = nerr;
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 2'd0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'd0, 0, 2'd0, 0);
    endtask

    initial begin
        logic [3:0] rps;
        rst_n = 1'b0; tick = 0; park_valid = 0; park_slot = 0;
        exit_valid = 0; exit_slot = 0; fee_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Basic: park slot 0 at hour 3, stay 5 hours.
        ticks(3);
        step(0, 1, 4'b0001, 0, 2'd0, 0);
        ticks(5);
        step(0, 0, 4'd0, 1, 2'd0, 0);
        chk("basic_ready_low", 8'(a_ready), 8'd0);
        idle(1);
        chk("basic_fv_not_yet", 8'(a_fv), 8'd0);
        idle(1);
        chk("basic_fv", 8'(a_fv), 8'd1);
        chk("basic_dur", 8'(a_dur), 8'd5);
        chk("basic_fee", a_fee, 8'd10);
        step(0, 0, 4'd0, 0, 2'd0, 1);
        chk("basic_busy_clear", 8'(a_busy), 8'd0);

        // Wrap-around stay: park at 14, exit at 2.
        ticks(6);
        step(0, 1, 4'b0100, 0, 2'd0, 0);
        ticks(4);
        step(0, 0, 4'd0, 1, 2'd2, 0);
        idle(2);
        chk("wrap_dur", 8'(a_dur), 8'd4);
        chk("wrap_fee", a_fee, 8'd8);
        step(0, 0, 4'd0, 0, 2'd0, 1);

        // Zero stay gets the minimum charge.
        step(0, 1, 4'b0010, 0, 2'd0, 0);
        step(0, 0, 4'd0, 1, 2'd1, 0);
        idle(2);
        chk("zero_dur", 8'(a_dur), 8'd0);
        chk("zero_fee", a_fee, 8'd2);
        step(0, 0, 4'd0, 0, 2'd0, 1);

        // Rejected requests.
        step(0, 0, 4'd0, 1, 2'd3, 0);
        chk("exit_free_err", 8'(a_err), 8'd1);
        chk("exit_free_ready", 8'(a_ready), 8'd1);
        idle(1);
        chk("err_one_cycle", 8'(a_err), 8'd0);
        step(0, 1, 4'b0011, 0, 2'd0, 0);
        chk("multihot_err", 8'(a_err), 8'd1);
        step(0, 1, 4'b0000, 0, 2'd0, 0);
        chk("full_no_err", 8'(a_err), 8'd0);

        // Same-edge park and exit of one slot: exit sees it free.
        step(0, 1, 4'b0001, 1, 2'd0, 0);
        chk("same_edge_err", 8'(a_err), 8'd1);

        // Concurrency: park slot 1 with a tick while slot 0 exits; fee held without ack.
        ticks(2);
        step(0, 0, 4'd0, 1, 2'd0, 0);
        step(1, 1, 4'b0010, 0, 2'd0, 1);
        idle(1);
        step(0, 1, 4'b0001, 0, 2'd0, 0);
        chk("park_done_err", 8'(a_err), 8'd1);
        idle(5);
        chk("held_fv", 8'(a_fv), 8'd1);
        chk("held_dur", 8'(a_dur), 8'd2);
        step(0, 0, 4'd0, 0, 2'd0, 1);
        step(0, 0, 4'd0, 1, 2'd1, 0);
        idle(2);
        chk("conc_slot1_dur", 8'(a_dur), 8'd1);
        step(0, 0, 4'd0, 0, 2'd0, 1);

        // Reset in MUL aborts the exit immediately.
        step(0, 1, 4'b1000, 0, 2'd0, 0);
        ticks(3);
        step(0, 0, 4'd0, 1, 2'd3, 0);
        idle(1);
        #2;
        rst_n = 1'b0;
        tick = 0; park_valid = 0; park_slot = 0; exit_valid = 0; exit_slot = 0; fee_ack = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all();

        // 15-hour stay at RATE 15 gives the maximum fee.
        step(0, 1, 4'b1000, 0, 2'd0, 0);
        ticks(15);
        step(0, 0, 4'd0, 1, 2'd3, 0);
        idle(2);
        chk("max_dur", 8'(b_dur), 8'd15);
        chk("max_fee", b_fee, 8'd225);
        step(0, 0, 4'd0, 0, 2'd0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rps = 4'b0001 << $urandom_range(0, 3);
            else rps = 4'($urandom_range(0, 15));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rps,
                 $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
